// File: rtl/bus_pkg.sv
// bus_pkg: shared widths and types for mem_arbiter; data width follows `XLEN (32 when not set).
`ifndef XLEN
`define XLEN 32
`endif
package bus_pkg;
    localparam int STRB = `XLEN / 8;
    typedef struct packed {
        logic [`XLEN-1:0] addr;
        logic [STRB-1:0]  wstrb;
        logic [`XLEN-1:0] wdata;
    } bus_req_t;
    typedef enum logic [1:0] {IDLE, RD_PEND, LOCKED} arb_state_e;
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: one-hot grant to the first request at or after (ptr+1) mod NREQ.
module rr_pick #(
    parameter int NREQ = 2,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        // scan farthest to nearest so the nearest requester overwrites last
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[IW'(j)]) begin
                gnt = '0;
                gnt[IW'(j)] = 1'b1;
                idx = IW'(j);
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port memory among NREQ masters.
// Define MEM_ARB_LOCK_EN to add req_lock, which keeps the grant on one owner for atomic sequences.
module mem_arbiter
    import bus_pkg::*;
#(
    parameter int XLEN = `XLEN,
    parameter int NREQ = 2,
    localparam int IW = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req,
`ifdef MEM_ARB_LOCK_EN
    input  logic [NREQ-1:0]      req_lock,
`endif
    input  logic [NREQ*XLEN-1:0] req_addr,
    input  logic [NREQ*STRB-1:0] req_wstrb,
    input  logic [NREQ*XLEN-1:0] req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [XLEN-1:0]      rdata,
    output logic                 mem_en,
    output logic [STRB-1:0]      mem_wstrb,
    output logic [XLEN-1:0]      mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic [XLEN-1:0]      mem_rdata
);
    arb_state_e      state, state_d;
    logic [IW-1:0]   ptr, ptr_d, win, owner, owner_d, pend_id;
    logic [NREQ-1:0] elig;
    logic            pend, rd_gnt, lock_d;
    bus_req_t        slot;

    // while locked only the owner is eligible; nothing is granted in reset
    assign elig = !resetn ? '0 : (state == LOCKED) ? req & (NREQ'(1) << owner) : req;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req(elig),
        .ptr(ptr),
        .gnt(gnt),
        .idx(win)
    );

    assign slot = '{addr:  req_addr[win*XLEN +: XLEN],
                    wstrb: req_wstrb[win*STRB +: STRB],
                    wdata: req_wdata[win*XLEN +: XLEN]};
    assign rd_gnt = mem_en && (slot.wstrb == '0);

`ifdef MEM_ARB_LOCK_EN
    assign lock_d = mem_en && req_lock[win];
`else
    assign lock_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            ptr     <= IW'(NREQ - 1);
            owner   <= '0;
            pend    <= 1'b0;
            pend_id <= '0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            owner   <= owner_d;
            pend    <= rd_gnt;
            pend_id <= win;
        end
    end

    // an owner grant without lock, or an idle owner cycle, leaves LOCKED
    always_comb begin
        state_d = lock_d ? LOCKED : rd_gnt ? RD_PEND : IDLE;
        ptr_d   = (mem_en && state != LOCKED) ? win : ptr;
        owner_d = lock_d ? win : owner;
    end

    always_comb begin
        mem_en    = |gnt;
        mem_addr  = mem_en ? slot.addr : '0;
        mem_wstrb = mem_en ? slot.wstrb : '0;
        mem_wdata = mem_en ? slot.wdata : '0;
        rvalid    = pend ? NREQ'(1) << pend_id : '0;
        rdata     = pend ? mem_rdata : '0;
    end
endmodule
